two_port_ram: RTL and testbench

Parametrised simple dual-port synchronous RAM: one write port, one read port, one clock. It generalises the one-port RAM with:
- per-lane write masks
- a selectable read-during-write mode
- a registered read with a valid flag
- a built-in clear sequencer that zeroes every location after reset

It serves as the data/register storage primitive for lab datapaths and for FIFOs built on top of it.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_clear_seq.sv | 36 +++
 rtl/two_port_ram.sv | 68 ++++++
 tb/tb_two_port_ram.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants, FSM encoding and the lane-merge helper for the two-port RAM.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int MAX_DW  = 256;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  // Callers zero-extend into MAX_DW and truncate the result back to their width.
  function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0] mask,
                                                   input logic [MAX_DW-1:0] nw,
                                                   input logic [MAX_DW-1:0] old,
                                                   input int lane_w);
    logic [MAX_DW-1:0] res;
    for (int b = 0; b < MAX_DW; b++) res[b] = mask[b / lane_w] ? nw[b] : old[b];
    return res;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, then idles in READY.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  state_t state, state_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_addr == {ADDR_WIDTH{1'b1}}) state_nx = READY;
  end

  always_comb begin
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR) && !rst;
  end

endmodule

// File: rtl/two_port_ram.sv
// Simple dual-port RAM with lane masks, selectable read-during-write and self-clear after reset.
module two_port_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_WIDTH = 4,
  parameter int RDW_MODE   = 0,
  localparam int LANES     = DATA_WIDTH / LANE_WIDTH,
  localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [LANES-1:0]      wr_mask,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
    $fatal(1, "two_port_ram: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (DATA_WIDTH > MAX_DW) begin : g_bad_width
    $fatal(1, "two_port_ram: DATA_WIDTH exceeds ram_pkg::MAX_DW");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
    .clk(clk), .rst(rst), .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wr_merge, mem_wdata, rd_next;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we, user_rd;

  assign wr_merge  = DATA_WIDTH'(lane_merge(MAX_DW'(wr_mask), MAX_DW'(wr_data),
                                            MAX_DW'(mem[wr_addr]), LANE_WIDTH));
  assign mem_we    = clr_we || (wr_en && !busy && |wr_mask);
  assign mem_addr  = clr_we ? clr_addr : wr_addr;
  assign mem_wdata = clr_we ? '0 : wr_merge;
  assign user_rd   = rd_en && !busy;

  // wr_merge already equals the bypass merge when both ports hit the same word.
  assign rd_next = (RDW_MODE == RDW_NEW && wr_en && wr_addr == rd_addr) ? wr_merge : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= user_rd;
      if (user_rd) rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_two_port_ram.sv
// Directed bench: one DUT per read-during-write mode, driven from shared stimulus.
module tb_two_port_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [5:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] wr_mask = '0;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1, busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  two_port_ram #(.RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .busy(busy0)
  );

  two_port_ram #(.RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input logic [1:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [7:0] exp0, input logic [7:0] exp1);
    n_checks++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== exp0) begin
      n_fail++;
      $display("FAIL %s mode0: valid=%b data=%h, want valid=1 data=%h", name, rd_valid0, rd_data0, exp0);
    end
    n_checks++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== exp1) begin
      n_fail++;
      $display("FAIL %s mode1: valid=%b data=%h, want valid=1 data=%h", name, rd_valid1, rd_data1, exp1);
    end
  endtask

  // Releases reset and counts edges until busy drops; expects DEPTH=64.
  task automatic release_and_count(input string name);
    int n;
    rst = 1'b0;
    n = 0;
    while ((busy0 || busy1) && n < 200) begin
      tick();
      n++;
      if (n < 64 && (busy0 !== 1'b1 || busy1 !== 1'b1)) break;
    end
    n_checks++;
    if (n != 64 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: busy low after %0d edges (busy0=%b busy1=%b), want 64", name, n, busy0, busy1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (rd_data0 !== 8'h00 || rd_valid0 !== 1'b0 || busy0 !== 1'b1 ||
        rd_data1 !== 8'h00 || rd_valid1 !== 1'b0 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: d0=%h v0=%b b0=%b d1=%h v1=%b b1=%b, want 00 0 1", rd_data0,
               rd_valid0, busy0, rd_data1, rd_valid1, busy1);
    end
    release_and_count("clear_duration");
  endtask

  task automatic test_clear_contents();
    for (int a = 0; a < 64; a++) begin
      rd_en = 1'b1; rd_addr = 6'(a);
      tick();
      check_rd($sformatf("clear_addr%0d", a), 8'h00, 8'h00);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_write_read();
    do_write(6'd3, 8'hA5, 2'b11);
    do_read(6'd3);
    check_rd("write_full", 8'hA5, 8'hA5);
    do_write(6'd3, 8'hFF, 2'b01);
    do_read(6'd3);
    check_rd("write_low_lane", 8'hAF, 8'hAF);
    do_write(6'd3, 8'h00, 2'b00);
    do_read(6'd3);
    check_rd("write_mask_zero", 8'hAF, 8'hAF);
  endtask

  task automatic test_rd_hold();
    tick();
    n_checks++;
    if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0 || rd_data0 !== 8'hAF || rd_data1 !== 8'hAF) begin
      n_fail++;
      $display("FAIL rd_hold: v0=%b d0=%h v1=%b d1=%h, want 0 AF", rd_valid0, rd_data0, rd_valid1, rd_data1);
    end
  endtask

  task automatic test_rdw();
    do_write(6'd7, 8'h12, 2'b11);
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 8'h34; wr_mask = 2'b11;
    rd_en = 1'b1; rd_addr = 6'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_rd("rdw_full", 8'h12, 8'h34);
    do_write(6'd7, 8'h12, 2'b11);
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 8'h34; wr_mask = 2'b10;
    rd_en = 1'b1; rd_addr = 6'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_rd("rdw_high_lane", 8'h12, 8'h32);
    do_read(6'd7);
    check_rd("rdw_after", 8'h32, 8'h32);
  endtask

  task automatic test_back_to_back();
    // Write address k while reading address k-1 written the edge before.
    do_write(6'd20, 8'h01, 2'b11);
    for (int k = 21; k < 25; k++) begin
      wr_en = 1'b1; wr_addr = 6'(k); wr_data = 8'(k - 19); wr_mask = 2'b11;
      rd_en = 1'b1; rd_addr = 6'(k - 1);
      tick();
      check_rd($sformatf("b2b_%0d", k - 1), 8'(k - 20), 8'(k - 20));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    do_read(6'd24);
    check_rd("b2b_24", 8'h05, 8'h05);
  endtask

  task automatic test_reset_mid_clear();
    do_write(6'd10, 8'h5A, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    release_and_count("restart_duration");
    do_read(6'd10);
    check_rd("restart_cleared", 8'h00, 8'h00);
    do_read(6'd7);
    check_rd("restart_cleared7", 8'h00, 8'h00);
  endtask

  task automatic test_busy_ignore();
    do_write(6'd0, 8'h11, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'h77; wr_mask = 2'b11;
    rd_en = 1'b1; rd_addr = 6'd0;
    tick();
    n_checks++;
    if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_no_valid: v0=%b v1=%b, want 0", rd_valid0, rd_valid1);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 80; i++) tick();
    do_read(6'd0);
    check_rd("busy_write_ignored", 8'h00, 8'h00);
  endtask

  initial begin
    test_reset();
    test_clear_contents();
    test_write_read();
    test_rd_hold();
    test_rdw();
    test_back_to_back();
    test_reset_mid_clear();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
